cdb_arbiter: RTL

Round-robin arbiter for the common data bus (CDB) of the Qu processor. Functional units present completed results as (tag, data) pairs. The arbiter grants one per cycle and broadcasts it on a registered CDB. Reservation-station entries use the broadcast to clear their qj/qk dependencies, so the schedule stage can issue those entries. The CDB is the single shared writeback path between execution and the reservation station / register status logic.

---
 rtl/qu_common_pkg.sv | 17 +
 rtl/cdb_arbiter_rr_arbiter.sv | 27 ++
 rtl/cdb_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/qu_common_pkg.sv
// rtl/qu_common_pkg.sv - shared Qu types and constants for the common data bus
package qu_common_pkg;

    localparam int CDB_N_REQ    = 4;
    localparam int CDB_TAG_W    = 6;
    localparam int CDB_DATA_W   = 32;
    localparam int CDB_TAG_NONE = 0;

    typedef logic [CDB_TAG_W-1:0] cdb_tag_t;

    typedef struct packed {
        logic                  valid;
        cdb_tag_t              tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational round-robin picker, generic over N
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    // Walk from the lowest to the highest priority slot so the last hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int p;
            p = (int'(ptr) + k) % N;
            if (req[p]) begin
                grant    = '0;
                grant[p] = 1'b1;
                idx      = p[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with registered (tag, data) broadcast
module cdb_arbiter
    import qu_common_pkg::*;
#(
    parameter int N_REQ  = CDB_N_REQ,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      err_zero_tag,
    output logic [31:0]               bcast_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     ptr_next;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;
    logic              tag_none;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign req_ready = (en && !flush && !rst) ? grant : '0;
    assign xfer      = |req_ready;
    assign tag_none  = (sel_tag == TAG_W'(CDB_TAG_NONE));
    // Explicit wrap keeps non-power-of-two N_REQ inside 0..N_REQ-1.
    assign ptr_next  = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_tag  = sel_tag  | req_tag[i*TAG_W +: TAG_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            err_zero_tag <= 1'b0;
            bcast_cnt    <= '0;
        end else begin
            cdb_valid <= xfer && !tag_none;
            if (xfer) begin
                rr_ptr <= ptr_next;
                if (tag_none) begin
                    err_zero_tag <= 1'b1;
                end else begin
                    cdb_tag   <= sel_tag;
                    cdb_data  <= sel_data;
                    bcast_cnt <= bcast_cnt + 32'd1;
                end
            end
        end
    end

endmodule
